uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a small write-side FIFO and a valid/ready push interface. It drives `usb_rs232_txd` from on-chip logic and replaces the fixed 8N1, single-byte, trigger-based sender. Frame format (data width, parity, stop bits, bit order) and baud rate are set at elaboration. Host logic pushes words without waiting for a frame to finish.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity codes, FSM state encoding,
// baud divisor rounding and FIFO width helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int baud_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // The count must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and same-cycle push/pop.
// The head word is readable combinationally so a pop can load it at once.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + CNT_W'(1);
    else if (do_pop && !do_push)
      count_next = count_reg - CNT_W'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(do_push);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(do_pop);
      count_reg  <= count_next;
      full_reg   <= (count_next == CNT_W'(DEPTH));
      empty_reg  <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with elaboration-time frame format and a small push FIFO;
// frames are sent back to back while words remain queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 40_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             user_clock,
  input  logic                             rst,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             busy,
  output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count,
  output logic                             usb_rs232_txd
);
  localparam int DIV    = baud_divisor(CLK_HZ, BAUD);
  localparam int BAUD_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int CNT_W  = cnt_width(FIFO_DEPTH);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal configuration");
  end

  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;

  assign tx_ready = ~fifo_full;
  assign push     = tx_valid & tx_ready;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (user_clock),
    .srst      (rst),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  logic [2:0]           state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 txd_reg, txd_next;
  logic                 busy_reg;
  logic                 baud_done;
  logic [CNT_W-1:0]     count_next;

  function automatic logic head_bit(input logic [DATA_BITS-1:0] s);
    return (MSB_FIRST != 0) ? s[DATA_BITS-1] : s[0];
  endfunction

  function automatic logic [DATA_BITS-1:0] advance(input logic [DATA_BITS-1:0] s);
    return (MSB_FIRST != 0) ? {s[DATA_BITS-2:0], 1'b0} : {1'b0, s[DATA_BITS-1:1]};
  endfunction

  assign baud_done = (baud_reg == BAUD_W'(DIV - 1));

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + BAUD_W'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    txd_next   = txd_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        txd_next  = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          par_next   = 1'b0;
          txd_next   = 1'b0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          txd_next   = head_bit(shift_reg);
          par_next   = par_reg ^ head_bit(shift_reg);
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == 4'(DATA_BITS - 1)) begin
            bit_next = '0;
            if (PARITY != PAR_NONE) begin
              txd_next   = (PARITY == PAR_ODD) ? ~par_reg : par_reg;
              state_next = ST_PAR;
            end else begin
              txd_next   = 1'b1;
              state_next = ST_STOP;
            end
          end else begin
            shift_next = advance(shift_reg);
            txd_next   = head_bit(advance(shift_reg));
            par_next   = par_reg ^ head_bit(advance(shift_reg));
            bit_next   = bit_reg + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          txd_next   = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when a word is waiting.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_data;
              par_next   = 1'b0;
              txd_next   = 1'b0;
              state_next = ST_START;
            end else begin
              txd_next   = 1'b1;
              state_next = ST_IDLE;
            end
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      default: begin
        baud_next  = '0;
        txd_next   = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge user_clock) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      txd_reg   <= txd_next;
      busy_reg  <= (state_next != ST_IDLE) || (count_next != '0);
    end
  end

  assign usb_rs232_txd = txd_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations share one stimulus stream and
// are compared every cycle against a frame-level model, plus directed frames.
module tb_uart_tx_fifo;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  always #5 clk = ~clk;

  logic       rdy0, busy0, txd0, rdy1, busy1, txd1, rdy2, busy2, txd2;
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4)) dut0 (
    .user_clock(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy0), .busy(busy0), .fifo_count(cnt0), .usb_rs232_txd(txd0));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .MSB_FIRST(0), .FIFO_DEPTH(4)) dut1 (
    .user_clock(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
    .tx_ready(rdy1), .busy(busy1), .fifo_count(cnt1), .usb_rs232_txd(txd1));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(300_000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .MSB_FIRST(1), .FIFO_DEPTH(2)) dut2 (
    .user_clock(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy2), .busy(busy2), .fifo_count(cnt2), .usb_rs232_txd(txd2));

  logic       txd_a [NI];
  logic       rdy_a [NI];
  logic       busy_a[NI];
  logic [6:0] cnt_a [NI];
  assign txd_a[0] = txd0;  assign txd_a[1] = txd1;  assign txd_a[2] = txd2;
  assign rdy_a[0] = rdy0;  assign rdy_a[1] = rdy1;  assign rdy_a[2] = rdy2;
  assign busy_a[0] = busy0; assign busy_a[1] = busy1; assign busy_a[2] = busy2;
  assign cnt_a[0] = {4'b0, cnt0};
  assign cnt_a[1] = {4'b0, cnt1};
  assign cnt_a[2] = {5'b0, cnt2};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Configuration of each instance; 1 MHz / 300 kbit/s rounds to 3 cycles per bit.
  function automatic int cfg_div(input int i);   return (i == 2) ? 3 : 10; endfunction
  function automatic int cfg_bits(input int i);  return (i == 1) ? 7 : 8; endfunction
  function automatic int cfg_par(input int i);   return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int cfg_stop(input int i);  return (i == 1) ? 2 : 1; endfunction
  function automatic bit cfg_msb(input int i);   return (i == 2); endfunction
  function automatic int cfg_depth(input int i); return (i == 2) ? 2 : 4; endfunction

  function automatic int frame_bits(input int i);
    return 1 + cfg_bits(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i);
  endfunction

  // Line-order bit image of one frame: start, data, optional parity, stop ones.
  function automatic logic [15:0] frame_of(input int i, input logic [7:0] w);
    logic [15:0] f;
    logic        p;
    logic        b;
    int          nb;
    f  = '1;
    p  = 1'b0;
    nb = cfg_bits(i);
    f[0] = 1'b0;
    for (int j = 0; j < nb; j++) begin
      b = cfg_msb(i) ? w[nb - 1 - j] : w[j];
      f[1 + j] = b;
      p ^= b;
    end
    if (cfg_par(i) != 0)
      f[1 + nb] = (cfg_par(i) == 2) ? p : ~p;
    return f;
  endfunction

  // Reference model: a word queue and the frame currently on the line.
  logic [7:0]  mq[NI][64];
  int          mq_n[NI];
  logic [15:0] fb[NI];
  int          flen[NI];
  int          fpos[NI];
  logic        exp_txd[NI], exp_busy[NI], exp_ready[NI];
  int          exp_cnt[NI];

  logic       s_rst = 1'b1, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;

  always @(posedge clk) begin
    s_rst   <= rst;
    s_valid <= tx_valid;
    s_data  <= tx_data;
  end

  task automatic model_step(input int i);
    logic       ready_prev;
    logic       cur;
    logic       in_frame;
    logic [7:0] mask;
    mask = 8'((9'h1 << cfg_bits(i)) - 9'h1);
    if (s_rst) begin
      mq_n[i] = 0;
      fpos[i] = 0;
      flen[i] = 0;
      exp_txd[i] = 1'b1;
      exp_busy[i] = 1'b0;
      exp_ready[i] = 1'b1;
      exp_cnt[i] = 0;
    end else begin
      ready_prev = (mq_n[i] != cfg_depth(i));
      in_frame = 1'b1;
      if (fpos[i] < flen[i]) begin
        cur = fb[i][fpos[i] / cfg_div(i)];
        fpos[i]++;
      end else if (mq_n[i] > 0) begin
        fb[i] = frame_of(i, mq[i][0]);
        for (int j = 0; j < mq_n[i] - 1; j++) mq[i][j] = mq[i][j + 1];
        mq_n[i]--;
        flen[i] = frame_bits(i) * cfg_div(i);
        cur = fb[i][0];
        fpos[i] = 1;
      end else begin
        cur = 1'b1;
        in_frame = 1'b0;
      end
      if (s_valid && ready_prev) begin
        mq[i][mq_n[i]] = s_data & mask;
        mq_n[i]++;
      end
      exp_txd[i]   = cur;
      exp_cnt[i]   = mq_n[i];
      exp_ready[i] = (mq_n[i] != cfg_depth(i));
      exp_busy[i]  = in_frame || (mq_n[i] != 0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      model_step(i);
      chk("txd", i, txd_a[i], exp_txd[i]);
      chk("fifo_count", i, cnt_a[i], exp_cnt[i]);
      chk("tx_ready", i, rdy_a[i], exp_ready[i]);
      chk("busy", i, busy_a[i], exp_busy[i]);
    end
  end

  typedef struct {
    int         inst;
    logic [7:0] data;
    string      pattern;
  } vec_t;

  function automatic vec_t mk(input int inst, input logic [7:0] d, input string p);
    vec_t v;
    v.inst = inst;
    v.data = d;
    v.pattern = p;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy0 || busy1 || busy2) && n < bound) begin
      tick();
      n++;
    end
    for (int i = 0; i < NI; i++) chk("drain", i, busy_a[i], 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int   d;
    int   len;
    logic exp_b;
    d = cfg_div(v.inst);
    len = v.pattern.len() * d;
    do_reset();
    push_word(v.data);
    chk("latency_idle", v.inst, txd_a[v.inst], 1'b1);
    for (int c = 1; c <= len; c++) begin
      tick();
      exp_b = (v.pattern[(c - 1) / d] == "1");
      chk("frame_bit", v.inst, txd_a[v.inst], exp_b);
    end
    chk("busy_last_stop", v.inst, busy_a[v.inst], 1'b1);
    tick();
    chk("busy_after_frame", v.inst, busy_a[v.inst], 1'b0);
    chk("txd_after_frame", v.inst, txd_a[v.inst], 1'b1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = mk(0, 8'hA5, "0101001011");
    vecs[1] = mk(1, 8'h35, "01010110011");
    vecs[2] = mk(2, 8'h80, "01000000001");
    vecs[3] = mk(0, 8'h00, "0000000001");
    vecs[4] = mk(0, 8'hFF, "0111111111");
    vecs[5] = mk(1, 8'h7F, "01111111111");
    vecs[6] = mk(2, 8'h01, "00000000101");

    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_txd", i, txd_a[i], 1'b1);
      chk("reset_ready", i, rdy_a[i], 1'b1);
      chk("reset_busy", i, busy_a[i], 1'b0);
      chk("reset_count", i, cnt_a[i], 0);
    end
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Six pushes on consecutive cycles: one pops at once, four queue, one drops.
    do_reset();
    for (int k = 0; k < 6; k++) push_word(8'(8'h10 + k));
    chk("burst_count", 0, cnt_a[0], 4);
    chk("burst_ready", 0, rdy_a[0], 1'b0);
    chk("burst_count", 2, cnt_a[2], 2);
    chk("burst_ready", 2, rdy_a[2], 1'b0);
    wait_idle(1000);

    // Push on the very edge that pops the next word with two queued.
    do_reset();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (98) tick();
    chk("pre_pop_count", 0, cnt_a[0], 2);
    push_word(8'h44);
    chk("pop_push_count", 0, cnt_a[0], 2);
    chk("pop_push_start", 0, txd_a[0], 1'b0);
    wait_idle(1000);

    // Reset in the third data bit with two words queued.
    do_reset();
    push_word(8'h04);
    push_word(8'h55);
    push_word(8'h66);
    repeat (31) tick();
    chk("third_bit", 0, txd_a[0], 1'b1);
    chk("queued_before_rst", 0, cnt_a[0], 2);
    rst = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("midrst_txd", i, txd_a[i], 1'b1);
      chk("midrst_count", i, cnt_a[i], 0);
      chk("midrst_busy", i, busy_a[i], 1'b0);
      chk("midrst_ready", i, rdy_a[i], 1'b1);
    end
    rst = 1'b0;
    push_word(8'hC3);
    wait_idle(1000);

    // Random bursts with varying push rate and rare resets.
    begin
      int rate;
      rate = 20;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 500 == 0) rate = $urandom_range(5, 60);
        tx_valid = ($urandom_range(0, 99) < rate);
        tx_data  = 8'($urandom);
        rst      = ($urandom_range(0, 1999) == 0);
        tick();
      end
      tx_valid = 1'b0;
      rst = 1'b0;
    end
    wait_idle(1500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
